// File: rtl/motor_drive.sv
// Differential-drive PWM motor controller: mixes speed/turn into per-motor duty and direction,
// with dead time on direction reversal and inputs sampled only at period boundaries.
module motor_drive #(
    parameter int PWM_DIV      = 4,
    parameter int DEAD_PERIODS = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              enable_in,
    input  logic signed [8:0] speed,
    input  logic signed [8:0] turn,
    output logic              pwm_l_out,
    output logic              dir_l_out,
    output logic              pwm_r_out,
    output logic              dir_r_out,
    output logic              period_start_out
);

    localparam int DIV_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int DEAD_W = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RUN,
        ST_DEAD
    } state_t;

    function automatic logic signed [9:0] sat255(input logic signed [9:0] v);
        if (v > 10'sd255) return 10'sd255;
        if (v < -10'sd255) return -10'sd255;
        return v;
    endfunction

    function automatic logic [7:0] mag8(input logic signed [9:0] v);
        return v[9] ? 8'(-v) : v[7:0];
    endfunction

    logic [DIV_W-1:0]  r_div;
    logic [7:0]        r_step;
    logic              r_pstart;
    logic              w_tick;
    logic              w_boundary;
    logic [7:0]        w_step_nxt;

    logic signed [9:0] w_mix      [2];
    logic [7:0]        w_cmd_duty [2];
    logic              w_cmd_neg  [2];

    state_t            r_state    [2];
    state_t            w_state_nxt[2];
    logic [7:0]        r_duty     [2];
    logic [7:0]        w_duty_nxt [2];
    logic              r_dir      [2];
    logic              w_dir_nxt  [2];
    logic [DEAD_W-1:0] r_dead     [2];
    logic [DEAD_W-1:0] w_dead_nxt [2];
    logic              r_pwm      [2];
    logic              w_pwm_nxt  [2];

    assign w_tick     = (r_div == DIV_W'(PWM_DIV - 1));
    assign w_boundary = w_tick && (r_step == 8'd254);

    always_comb begin
        w_step_nxt = r_step;
        if (w_tick) begin
            w_step_nxt = (r_step == 8'd254) ? 8'd0 : r_step + 8'd1;
        end
    end

    // 10-bit mixing cannot overflow: 9-bit operands span -256..255
    assign w_mix[0] = $signed({speed[8], speed}) + $signed({turn[8], turn});
    assign w_mix[1] = $signed({speed[8], speed}) - $signed({turn[8], turn});

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_cmd_duty[i]  = mag8(sat255(w_mix[i]));
            w_cmd_neg[i]   = w_mix[i][9];
            w_state_nxt[i] = r_state[i];
            w_duty_nxt[i]  = r_duty[i];
            w_dir_nxt[i]   = r_dir[i];
            w_dead_nxt[i]  = r_dead[i];

            if (!enable_in) begin
                w_state_nxt[i] = ST_OFF;
            end else if (w_boundary) begin
                case (r_state[i])
                    ST_OFF: begin
                        w_state_nxt[i] = ST_RUN;
                        w_duty_nxt[i]  = w_cmd_duty[i];
                        if (w_cmd_duty[i] != 8'd0) w_dir_nxt[i] = w_cmd_neg[i];
                    end
                    ST_RUN: begin
                        if (w_cmd_duty[i] == 8'd0 || w_cmd_neg[i] == r_dir[i]) begin
                            w_duty_nxt[i] = w_cmd_duty[i];
                        end else begin
                            w_state_nxt[i] = ST_DEAD;
                            w_dead_nxt[i]  = '0;
                        end
                    end
                    ST_DEAD: begin
                        // A command that agrees with the held direction ends dead time early
                        if (w_cmd_duty[i] == 8'd0 || w_cmd_neg[i] == r_dir[i]) begin
                            w_state_nxt[i] = ST_RUN;
                            w_duty_nxt[i]  = w_cmd_duty[i];
                        end else if (r_dead[i] == DEAD_W'(DEAD_PERIODS - 1)) begin
                            w_state_nxt[i] = ST_RUN;
                            w_duty_nxt[i]  = w_cmd_duty[i];
                            w_dir_nxt[i]   = w_cmd_neg[i];
                        end else begin
                            w_dead_nxt[i] = r_dead[i] + DEAD_W'(1);
                        end
                    end
                    default: w_state_nxt[i] = ST_OFF;
                endcase
            end

            w_pwm_nxt[i] = (w_state_nxt[i] == ST_RUN) && (w_step_nxt < w_duty_nxt[i]);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_div    <= '0;
            r_step   <= '0;
            r_pstart <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= ST_OFF;
                r_duty[i]  <= '0;
                r_dir[i]   <= 1'b0;
                r_dead[i]  <= '0;
                r_pwm[i]   <= 1'b0;
            end
        end else begin
            r_div    <= w_tick ? '0 : r_div + DIV_W'(1);
            r_step   <= w_step_nxt;
            r_pstart <= w_boundary;
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_duty[i]  <= w_duty_nxt[i];
                r_dir[i]   <= w_dir_nxt[i];
                r_dead[i]  <= w_dead_nxt[i];
                r_pwm[i]   <= w_pwm_nxt[i];
            end
        end
    end

    assign pwm_l_out        = r_pwm[0];
    assign dir_l_out        = r_dir[0];
    assign pwm_r_out        = r_pwm[1];
    assign dir_r_out        = r_dir[1];
    assign period_start_out = r_pstart;

endmodule

// File: tb/tb_motor_drive.sv
// Scoreboard bench for motor_drive: stimulus queues the expected high-time and direction of each
// period; a negedge monitor measures every period from its start pulse and compares.
module tb_motor_drive;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic signed [8:0] speed;
    logic signed [8:0] turn;
    logic              pwm_l, dir_l, pwm_r, dir_r, pstart;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int hl;
        int hr;
        int dl;
        int dr;
    } exp_t;

    exp_t exp_q[$];

    motor_drive #(.PWM_DIV(1), .DEAD_PERIODS(2)) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .enable_in       (enable),
        .speed           (speed),
        .turn            (turn),
        .pwm_l_out       (pwm_l),
        .dir_l_out       (dir_l),
        .pwm_r_out       (pwm_r),
        .dir_r_out       (dir_r),
        .period_start_out(pstart)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push(input int hl, input int hr, input int dl, input int dr);
        exp_t e;
        e.hl = hl; e.hr = hr; e.dl = dl; e.dr = dr;
        exp_q.push_back(e);
    endtask

    task automatic wait_start();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (pstart) return;
        end
        $display("FAIL period_start_timeout actual=none expected=pulse");
        $fatal(1, "no period start");
    endtask

    task automatic measure_to_start(output int n);
        n = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            n++;
            if (pstart) return;
        end
        $display("FAIL first_start_timeout actual=none expected=pulse");
        $fatal(1, "no period start after reset");
    endtask

    // Monitor: one 255-cycle window per period start pulse
    int win_n = 0, hi_l = 0, hi_r = 0, dl0 = 0, dr0 = 0, shape_bad = 0, dir_bad = 0, per_idx = 0;
    bit active = 0, prev_l = 0, prev_r = 0;

    always @(negedge clk) begin
        exp_t e;
        if (pstart) begin
            if (active) check("start_spacing", win_n, 255);
            active = 1; win_n = 0; hi_l = 0; hi_r = 0; shape_bad = 0; dir_bad = 0;
            dl0 = int'(dir_l); dr0 = int'(dir_r); prev_l = 1'b1; prev_r = 1'b1;
        end
        if (active) begin
            hi_l += int'(pwm_l);
            hi_r += int'(pwm_r);
            if ((pwm_l && !prev_l) || (pwm_r && !prev_r)) shape_bad = 1;
            if (int'(dir_l) != dl0 || int'(dir_r) != dr0) dir_bad = 1;
            prev_l = pwm_l;
            prev_r = pwm_r;
            win_n++;
            if (win_n == 255) begin
                per_idx++;
                active = 0;
                win_n = 0;
                if (exp_q.size() == 0) begin
                    check($sformatf("p%0d_unexpected_period", per_idx), 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("p%0d_high_l", per_idx), hi_l, e.hl);
                    check($sformatf("p%0d_high_r", per_idx), hi_r, e.hr);
                    check($sformatf("p%0d_dir_l", per_idx), dl0, e.dl);
                    check($sformatf("p%0d_dir_r", per_idx), dr0, e.dr);
                    check($sformatf("p%0d_shape", per_idx), shape_bad + dir_bad, 0);
                end
            end
        end
    end

    initial begin
        int n;
        rst_n  = 1'b0;
        enable = 1'b1;
        speed  = 9'sd100;
        turn   = 9'sd0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({pwm_l, dir_l, pwm_r, dir_r, pstart}), 0);
        push(100, 100, 0, 0);
        #2 rst_n = 1'b1;
        measure_to_start(n);
        check("first_boundary", n, 255);

        // P1: mid-period speed change only affects the next period
        repeat (10) @(negedge clk);
        speed = 9'sd30;
        push(30, 30, 0, 0);
        wait_start();

        // P2: left saturates
        repeat (5) @(negedge clk);
        speed = 9'sd200; turn = 9'sd100;
        push(255, 100, 0, 0);
        wait_start();

        // P3: pure left turn reverses left only; right keeps running
        repeat (5) @(negedge clk);
        speed = 9'sd0; turn = -9'sd60;
        push(0, 60, 0, 0);
        push(0, 60, 0, 0);
        push(60, 60, 1, 0);
        repeat (3) wait_start();

        // P6: zero command keeps directions
        repeat (5) @(negedge clk);
        speed = 9'sd0; turn = 9'sd0;
        push(0, 0, 1, 0);
        wait_start();

        // P7: left reverses into dead time
        repeat (5) @(negedge clk);
        speed = 9'sd50;
        push(0, 50, 1, 0);
        wait_start();

        // P8: left dead time cut short; right enters dead time
        repeat (5) @(negedge clk);
        speed = -9'sd40;
        push(40, 0, 1, 0);
        wait_start();

        // P9: right returns early; left runs full dead time
        repeat (5) @(negedge clk);
        speed = 9'sd50;
        push(0, 50, 1, 0);
        push(0, 50, 1, 0);
        push(50, 50, 0, 0);
        repeat (3) wait_start();

        // P12: full reverse from forward 50
        repeat (5) @(negedge clk);
        speed = -9'sd256;
        push(0, 0, 0, 0);
        push(0, 0, 0, 0);
        push(255, 255, 1, 1);
        repeat (3) wait_start();

        // P15: same direction, lower duty
        repeat (5) @(negedge clk);
        speed = -9'sd100;
        push(41, 41, 1, 1);
        wait_start();

        // P16: disable at step 40, re-enable forward at step 60
        repeat (40) @(negedge clk);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        enable = 1'b1;
        speed  = 9'sd100;
        push(21, 21, 0, 0);
        wait_start();

        // P17: reset at step 20 aborts the period
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_async", int'({pwm_l, dir_l, pwm_r, dir_r, pstart}), 0);
        repeat (4) @(negedge clk);
        check("reset_hold", int'({pwm_l, dir_l, pwm_r, dir_r, pstart}), 0);
        push(100, 100, 0, 0);
        #2 rst_n = 1'b1;
        measure_to_start(n);
        check("reset_boundary", n, 255);

        repeat (260) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("periods_seen", per_idx, 18);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
